// File: rtl/sig_pack.sv
// sig_pack: samples a 1-bit source once per clk, packs 32 consecutive samples
// into dsq (bit 0 oldest) and produces a registered clk/32 word clock pclk.
// A built-in PWM generator can replace the external input as the source.
module sig_pack #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned W           = 28
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sig_in,
    input  logic         sel_test,
    input  logic [W-1:0] tp_period,
    input  logic [W-1:0] tp_high,
    output logic [31:0]  dsq,
    output logic         pclk,
    output logic         word_stb
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [SYNC_STAGES-1:0] sync;
    logic                   sync_o;
    logic [W-1:0]           pcnt;
    logic [W-1:0]           per_s;
    logic [W-1:0]           hi_s;
    logic                   pwm_o;
    logic                   src;
    logic [31:0]            sh;
    logic [4:0]             bcnt;
    logic [4:0]             bcnt_next;
    logic [31:0]            sh_next;

    // Metastability synchroniser for the external input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], sig_in};
        end
    end

    assign sync_o = sync[SYNC_STAGES-1];

    // PWM counter; period/high-time shadows reload only at a period boundary
    // (or every cycle while the shadow period is zero).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt  <= '0;
            per_s <= '0;
            hi_s  <= '0;
        end else if (per_s == '0) begin
            pcnt  <= '0;
            per_s <= tp_period;
            hi_s  <= tp_high;
        end else if (pcnt == per_s - ONE) begin
            pcnt  <= '0;
            per_s <= tp_period;
            hi_s  <= tp_high;
        end else begin
            pcnt  <= pcnt + ONE;
        end
    end

    // Source selection and next-state values for the packer.
    always_comb begin
        pwm_o     = (pcnt < hi_s);
        src       = sel_test ? pwm_o : sync_o;
        bcnt_next = bcnt + 5'd1;
        sh_next   = {src, sh[31:1]};
    end

    // Shift register, bit counter, word output and word clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh       <= '0;
            bcnt     <= '0;
            dsq      <= '0;
            pclk     <= 1'b0;
            word_stb <= 1'b0;
        end else begin
            sh   <= sh_next;
            bcnt <= bcnt_next;
            pclk <= (bcnt_next < 5'd16);
            if (bcnt == 5'd31) begin
                dsq      <= sh_next;
                word_stb <= 1'b1;
            end else begin
                word_stb <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sig_pack.sv
// Testbench for sig_pack: directed scenarios plus randomized stimulus, every
// cycle compared against a sample-queue reference model.
module tb_sig_pack;

    localparam int unsigned S = 2;
    localparam int unsigned W = 28;

    logic         clk;
    logic         rst;
    logic         sig_in;
    logic         sel_test;
    logic [W-1:0] tp_period;
    logic [W-1:0] tp_high;
    logic [31:0]  dsq;
    logic         pclk;
    logic         word_stb;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state
    int unsigned m_per, m_hi, m_ph;
    int unsigned m_n;
    bit          sin_q[$];
    bit          samp_q[$];
    logic [31:0] m_dsq;
    logic        m_stb;

    sig_pack #(.SYNC_STAGES(S), .W(W)) dut (
        .clk(clk), .rst(rst), .sig_in(sig_in), .sel_test(sel_test),
        .tp_period(tp_period), .tp_high(tp_high),
        .dsq(dsq), .pclk(pclk), .word_stb(word_stb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        m_per = 0; m_hi = 0; m_ph = 0; m_n = 0;
        m_dsq = '0; m_stb = 1'b0;
        samp_q.delete();
        sin_q.delete();
        for (int i = 0; i < int'(S); i++) sin_q.push_back(1'b0);
    endtask

    // One clock edge of the reference: the sample is the PWM level (phase
    // below high time) or the input seen S edges ago; words are the last 32
    // samples, oldest in bit 0.
    task automatic model_edge();
        bit s;
        s = sel_test ? (m_ph < m_hi) : sin_q[0];
        if (m_per == 0 || m_ph == m_per - 1) begin
            m_ph  = 0;
            m_per = int'(tp_period);
            m_hi  = int'(tp_high);
        end else begin
            m_ph++;
        end
        void'(sin_q.pop_front());
        sin_q.push_back(sig_in);
        samp_q.push_back(s);
        m_n++;
        if (samp_q.size() == 32) begin
            for (int k = 0; k < 32; k++) m_dsq[k] = samp_q[k];
            samp_q.delete();
            m_stb = 1'b1;
        end else begin
            m_stb = 1'b0;
        end
    endtask

    task automatic check_all();
        chk("dsq", dsq, m_dsq);
        chk("word_stb", {31'd0, word_stb}, {31'd0, m_stb});
        chk("pclk", {31'd0, pclk}, {31'd0, (m_n != 0) && ((m_n % 32) < 16)});
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Reset held over three edges, then released mid-cycle.
    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_dsq", dsq, 32'h0);
        chk("rst_pclk", {31'd0, pclk}, 32'h0);
        chk("rst_stb", {31'd0, word_stb}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    initial begin
        int cnt;
        rst = 1'b1; sig_in = 1'b0; sel_test = 1'b1;
        tp_period = W'(8); tp_high = W'(3);
        model_reset();
        #12;
        chk("reset_dsq", dsq, 32'h0);
        chk("reset_pclk", {31'd0, pclk}, 32'h0);
        chk("reset_stb", {31'd0, word_stb}, 32'h0);
        rst = 1'b0;

        // PWM 8/3 from reset: three words
        ticks(32);
        chk("first_word_stb", {31'd0, word_stb}, 32'h1);
        ticks(64);

        // PWM 64/32, then high time 0, then high time beyond period
        tp_period = W'(64); tp_high = W'(32);
        ticks(128);
        tp_high = W'(0);
        ticks(160);
        chk("pwm_hi0", dsq, 32'h0000_0000);
        tp_high = W'(100);
        ticks(160);
        chk("pwm_hi_over", dsq, 32'hFFFF_FFFF);

        // high-time change mid-period takes effect at the boundary
        tp_period = W'(8); tp_high = W'(3);
        ticks(67);
        tp_high = W'(5);
        ticks(96);

        // word clock timing relative to the strobe
        cnt = 0;
        while (word_stb !== 1'b1 && cnt < 40) begin tick(); cnt++; end
        chk("stb_seen", {31'd0, word_stb}, 32'h1);
        cnt = 0;
        while (pclk !== 1'b0 && cnt < 40) begin tick(); cnt++; end
        chk("pclk_fall_after_stb", cnt, 32'd16);
        cnt = 0;
        while (pclk !== 1'b1 && cnt < 40) begin tick(); cnt++; end
        chk("pclk_low_len", cnt, 32'd16);
        chk("stb_at_rise", {31'd0, word_stb}, 32'h1);

        // external path, input held high from reset
        sel_test = 1'b0; sig_in = 1'b1;
        do_reset();
        ticks(32);
        chk("ext_first", dsq, 32'hFFFF_FFFC);
        ticks(32);
        chk("ext_second", dsq, 32'hFFFF_FFFF);

        // reset mid-word at bcnt=20
        sel_test = 1'b1; tp_period = W'(8); tp_high = W'(3);
        cnt = 0;
        while ((m_n % 32) != 20 && cnt < 64) begin tick(); cnt++; end
        chk("reach_bcnt20", m_n % 32, 32'd20);
        do_reset();
        cnt = 0;
        while (cnt < 40) begin
            tick();
            cnt++;
            if (word_stb === 1'b1) break;
        end
        chk("stb_after_release", cnt, 32'd32);
        ticks(64);

        // randomized stimulus
        for (int i = 0; i < 600; i++) begin
            if (i % 50 == 0) begin
                sel_test  = 1'($urandom_range(0, 1));
                tp_period = W'($urandom_range(0, 40));
                tp_high   = W'($urandom_range(0, 45));
            end
            sig_in = 1'($urandom);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
